// File: rtl/alu_pkg.sv
// Shared definitions for the Z80-style flag register: F bit positions, FSM states and bank reset value.
// The ALU_UNDOC_FLAGS_EN build option selects whether the undocumented Y/X bits (5 and 3) are kept.
package alu_pkg;

    localparam int S_BIT  = 7;
    localparam int Z_BIT  = 6;
    localparam int Y_BIT  = 5;
    localparam int H_BIT  = 4;
    localparam int X_BIT  = 3;
    localparam int PV_BIT = 2;
    localparam int N_BIT  = 1;
    localparam int C_BIT  = 0;

    typedef enum logic {
        IDLE = 1'b0,
        SWAP = 1'b1
    } state_t;

`ifdef ALU_UNDOC_FLAGS_EN
    localparam logic [7:0] F_KEEP_MASK = 8'hFF;
`else
    // Without the undocumented flags, Y and X are hard zero in both banks.
    localparam logic [7:0] F_KEEP_MASK = 8'hD7;
`endif

    localparam logic [7:0] F_RESET = F_KEEP_MASK;

    function automatic logic [7:0] merge_flags(input logic [7:0] old_f,
                                               input logic [7:0] new_f,
                                               input logic [7:0] mask);
        return ((old_f & ~mask) | (new_f & mask)) & F_KEEP_MASK;
    endfunction

endpackage

// File: rtl/alu_flag_reg.sv
// Main/shadow flag register pair with masked ALU updates, direct load and an EX AF swap FSM.
// Build option ALU_UNDOC_FLAGS_EN: source Y/X (bits 5/3) from result and keep them in F and F'.
module alu_flag_reg
    import alu_pkg::*;
#(
    parameter int ALU_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flag_valid,
    output logic                 flag_ready,
    input  logic                 s,
    input  logic                 z,
    input  logic                 h,
    input  logic                 pv,
    input  logic                 n,
    input  logic                 c,
    input  logic [ALU_WIDTH-1:0] result,
    input  logic [7:0]           update_mask,
    input  logic                 load_en,
    input  logic [7:0]           load_data,
    input  logic                 ex_af,
    output logic [7:0]           f_out,
    output logic [7:0]           f_shadow_out,
    output logic                 busy
);

    state_t     state;
    logic [7:0] f_reg;
    logic [7:0] f_shadow;
    logic [7:0] status_word;
    logic       accept;
    logic       unused_result;

    always_comb begin
        status_word         = '0;
        status_word[S_BIT]  = s;
        status_word[Z_BIT]  = z;
        status_word[H_BIT]  = h;
        status_word[PV_BIT] = pv;
        status_word[N_BIT]  = n;
        status_word[C_BIT]  = c;
`ifdef ALU_UNDOC_FLAGS_EN
        status_word[Y_BIT]  = result[5];
        status_word[X_BIT]  = result[3];
`endif
    end

    // Only bits 5 and 3 of the result ever reach F; the rest of the word is informational.
    assign unused_result = ^result;

    assign accept       = flag_valid & flag_ready;
    assign f_out        = f_reg;
    assign f_shadow_out = f_shadow;

    // In IDLE a load beats an accepted update, which beats a swap request; losers are dropped.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            f_reg      <= F_RESET;
            f_shadow   <= F_RESET;
            busy       <= 1'b0;
            flag_ready <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (load_en) begin
                        f_reg <= load_data & F_KEEP_MASK;
                    end else if (accept) begin
                        f_reg <= merge_flags(f_reg, status_word, update_mask);
                    end else if (ex_af) begin
                        state      <= SWAP;
                        busy       <= 1'b1;
                        flag_ready <= 1'b0;
                    end
                end
                SWAP: begin
                    f_reg      <= f_shadow;
                    f_shadow   <= f_reg;
                    state      <= IDLE;
                    busy       <= 1'b0;
                    flag_ready <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    flag_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_flag_reg.sv
// Self-checking bench for alu_flag_reg: directed scenarios followed by random traffic against a model.
// Honours ALU_UNDOC_FLAGS_EN the same way the design does.
module tb_alu_flag_reg;

    logic       clk;
    logic       reset_n;
    logic       flag_valid;
    logic       flag_ready;
    logic       s, z, h, pv, n, c;
    logic [7:0] result;
    logic [7:0] update_mask;
    logic       load_en;
    logic [7:0] load_data;
    logic       ex_af;
    logic [7:0] f_out;
    logic [7:0] f_shadow_out;
    logic       busy;

    int nChecks = 0;
    int nFail   = 0;

`ifdef ALU_UNDOC_FLAGS_EN
    localparam bit UNDOC = 1'b1;
`else
    localparam bit UNDOC = 1'b0;
`endif

    // Bits 5 and 3 are dropped unless the undocumented flags are built in.
    int keepMask;
    int resetVal;
    int mF;
    int mFs;
    bit mSwapping;

    alu_flag_reg #(.ALU_WIDTH(8)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .flag_valid   (flag_valid),
        .flag_ready   (flag_ready),
        .s            (s),
        .z            (z),
        .h            (h),
        .pv           (pv),
        .n            (n),
        .c            (c),
        .result       (result),
        .update_mask  (update_mask),
        .load_en      (load_en),
        .load_data    (load_data),
        .ex_af        (ex_af),
        .f_out        (f_out),
        .f_shadow_out (f_shadow_out),
        .busy         (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int statusWord();
        int w;
        w = 128 * s + 64 * z + 16 * h + 4 * pv + 2 * n + c;
        if (UNDOC) w = w + 32 * result[5] + 8 * result[3];
        return w;
    endfunction

    task automatic modelReset();
        mF        = resetVal;
        mFs       = resetVal;
        mSwapping = 1'b0;
    endtask

    // One clock edge of the architectural behaviour, read from the inputs present at that edge.
    task automatic modelStep();
        int tmp;
        int m;
        if (mSwapping) begin
            tmp       = mF;
            mF        = mFs;
            mFs       = tmp;
            mSwapping = 1'b0;
        end else if (load_en) begin
            mF = load_data & keepMask;
        end else if (flag_valid) begin
            m  = update_mask;
            mF = ((mF & (255 - m)) | (statusWord() & m)) & keepMask;
        end else if (ex_af) begin
            mSwapping = 1'b1;
        end
    endtask

    task automatic checkOutput(input string tag);
        nChecks++;
        assert (f_out === 8'(mF)) else begin
            nFail++;
            $error("[TB] FAIL %s f_out: observed %h expected %h", tag, f_out, 8'(mF));
        end
        nChecks++;
        assert (f_shadow_out === 8'(mFs)) else begin
            nFail++;
            $error("[TB] FAIL %s f_shadow_out: observed %h expected %h", tag, f_shadow_out, 8'(mFs));
        end
        nChecks++;
        assert (busy === mSwapping) else begin
            nFail++;
            $error("[TB] FAIL %s busy: observed %b expected %b", tag, busy, mSwapping);
        end
        nChecks++;
        assert (flag_ready === !mSwapping) else begin
            nFail++;
            $error("[TB] FAIL %s flag_ready: observed %b expected %b", tag, flag_ready, !mSwapping);
        end
    endtask

    task automatic applyStimulus(input bit valid, input bit [5:0] flags, input logic [7:0] res,
                                 input logic [7:0] mask, input bit ld, input logic [7:0] ldData,
                                 input bit ex);
        flag_valid  = valid;
        {s, z, h, pv, n, c} = flags;
        result      = res;
        update_mask = mask;
        load_en     = ld;
        load_data   = ldData;
        ex_af       = ex;
    endtask

    task automatic stepCycle(input string tag);
        @(posedge clk);
        modelStep();
        #1;
        checkOutput(tag);
    endtask

    initial begin
        keepMask = UNDOC ? 255 : (255 - 32 - 8);
        resetVal = keepMask;
        modelReset();
        reset_n = 1'b0;
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);

        // Reset held: both banks at reset value, ready, not busy.
        @(posedge clk);
        @(posedge clk);
        #1;
        checkOutput("reset");
        reset_n = 1'b1;
        stepCycle("postReset");

        // Masked update touches only C: s=0 z=1 h=0 pv=0 n=1 c=0, mask 0x01.
        applyStimulus(1'b1, 6'b010010, 8'h00, 8'h01, 1'b0, 8'h00, 1'b0);
        stepCycle("maskedUpdate");

        // Load beats a simultaneous update and swap request.
        applyStimulus(1'b1, 6'b111111, 8'hFF, 8'hFF, 1'b1, 8'h41, 1'b1);
        stepCycle("loadPriority");
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        stepCycle("loadIdle");

        // Swap request, then an update held valid across the SWAP cycle.
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        stepCycle("enterSwap");
        applyStimulus(1'b1, 6'b101001, 8'h28, 8'hFF, 1'b1, 8'h99, 1'b1);
        stepCycle("swapDone");
        applyStimulus(1'b1, 6'b101001, 8'h28, 8'hFF, 1'b0, 8'h00, 1'b0);
        stepCycle("stalledUpdate");
        applyStimulus(1'b1, 6'b000000, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        stepCycle("zeroMask");

        // Random traffic, with loads and swap requests kept fairly rare.
        for (int i = 0; i < 300; i++) begin
            applyStimulus($urandom_range(0, 1) == 1, 6'($urandom), 8'($urandom), 8'($urandom),
                          $urandom_range(0, 7) == 0, 8'($urandom), $urandom_range(0, 4) == 0);
            stepCycle("random");
        end

        // Reset asserted in the middle of a swap.
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        stepCycle("settle0");
        stepCycle("settle1");
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b1, 8'h3C, 1'b0);
        stepCycle("preSwapLoad");
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b1);
        stepCycle("enterSwap2");
        applyStimulus(1'b0, 6'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0);
        #2;
        reset_n = 1'b0;
        modelReset();
        #1;
        checkOutput("resetMidSwap");
        @(posedge clk);
        #1;
        checkOutput("resetHeld");
        reset_n = 1'b1;
        applyStimulus(1'b1, 6'b000001, 8'h00, 8'hFF, 1'b0, 8'h00, 1'b0);
        stepCycle("resumeUpdate");

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
        $finish;
    end

endmodule

// File: doc/alu_flag_reg.md
ALU_FLAG_REG -- requirements
Module: alu_flag_reg

Interface
REQ-001 SHALL have parameter ALU_WIDTH, default 8, the datapath width of the result operand.
REQ-002 SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port reset_n, input, 1 bit: asynchronous, active-low reset.
REQ-004 SHALL have port flag_valid, input, 1 bit: the ALU status word is valid this cycle.
REQ-005 SHALL have port flag_ready, output, 1 bit: the block can accept a status word this cycle.
REQ-006 SHALL have ports s, z, h, pv, n and c, inputs, 1 bit each: ALU status flags.
REQ-007 SHALL have port result, input, ALU_WIDTH bits: the ALU op_result.
REQ-008 SHALL have port update_mask, input, 8 bits: per-bit write enable into F, using the F bit layout.
REQ-009 SHALL have port load_en, input, 1 bit: load F directly (POP AF path).
REQ-010 SHALL have port load_data, input, 8 bits: the value loaded when load_en is high.
REQ-011 SHALL have port ex_af, input, 1 bit: request to exchange the main and shadow flag banks.
REQ-012 SHALL have port f_out, output, 8 bits: the current main F register.
REQ-013 SHALL have port f_shadow_out, output, 8 bits: the current shadow F' register.
REQ-014 SHALL have port busy, output, 1 bit: a swap is in progress.

Function
REQ-015 SHALL use the F layout 7:S, 6:Z, 5:Y, 4:H, 3:X, 2:PV, 1:N, 0:C.
REQ-016 SHALL accept a status word only on flag_valid & flag_ready, and SHALL apply it at that clock edge.
REQ-017 SHALL, on accept, write each bit i of F from the assembled status word when update_mask[i]=1 and hold bit i otherwise.
REQ-018 SHALL implement an FSM with states IDLE and SWAP.
REQ-019 SHALL drive flag_ready=1 in IDLE and flag_ready=0 in SWAP.
REQ-020 SHALL move IDLE->SWAP when ex_af=1 in IDLE and no load or accepted update occurs that cycle.
REQ-021 SHALL, in SWAP, exchange F and F' at the end of the cycle, then return to IDLE; busy=1 only in SWAP.
REQ-022 SHALL apply priority in IDLE as load_en > accepted update > ex_af; a lower-priority request is dropped, not queued.
REQ-023 SHALL ignore load_en, flag_valid and ex_af while in SWAP.
REQ-024 SHALL give a latency of 1 cycle: f_out reflects an accepted update or load on the cycle after the edge.
REQ-025 SHALL never write f_shadow_out except by a swap.
REQ-026 SHALL treat update_mask=0x00 as a legal accept that leaves F unchanged.

Reset
REQ-027 SHALL, while reset_n=0, immediately force F=0xFF, F'=0xFF, state=IDLE, busy=0 and flag_ready=1.
REQ-028 SHALL, when reset is asserted during SWAP, abort the swap with both banks at reset value.
REQ-029 SHALL resume normal operation on the first rising clk edge after reset_n deasserts.

Configuration
REQ-030 SHALL, with ALU_UNDOC_FLAGS_EN defined, source status bits 5 and 3 from result[5] and result[3], and SHALL load them from load_data on load_en.
REQ-031 SHALL, without ALU_UNDOC_FLAGS_EN, force bits 5 and 3 of F and F' to 0 after any write or load, with reset value 0xD7 in place of 0xFF.

Structure
REQ-032 SHALL place the flag bit index constants (S_BIT..C_BIT), the FSM state enum and the reset constant in shared package alu_pkg.
REQ-033 SHALL have no sub-module; the FSM and both bank registers are in one module.

Verification
REQ-034 SHALL verify reset: reset_n=0 -> f_out=0xFF and f_shadow_out=0xFF (0xD7 without the macro), flag_ready=1.
REQ-035 SHALL verify masked update: F=0xFF, flags s=0 z=1 h=0 pv=0 n=1 c=0, result=0x00, mask=0x01 -> F=0xFE.
REQ-036 SHALL verify load priority: load_en=1, load_data=0x41, flag_valid=1 and ex_af=1 in the same cycle -> F=0x41, no swap, busy stays 0.
REQ-037 SHALL verify swap: F=0x41, F'=0xFF, ex_af pulse -> busy=1 and flag_ready=0 for one cycle, then F=0xFF and F'=0x41.
REQ-038 SHALL verify a stalled update: flag_valid held during SWAP -> not accepted until the IDLE cycle, then applied to the post-swap F.
REQ-039 SHALL verify reset mid-swap: reset_n low during SWAP -> both banks at reset value and state=IDLE.
